// File: rtl/sgb_lcd_tap.sv
// PPU-to-ICD2 tap: reshapes the PPU pixel stream into whole LINE_PIX-pixel lines,
// zero-padding short lines, dropping excess pixels and faking vsync while the LCD is off.
module sgb_lcd_tap #(
  parameter int unsigned LINE_PIX = 160,
  parameter int unsigned FRAME_CE = 70224
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       gb_ce,
  input  logic       pix_valid,
  input  logic [1:0] pix_data,
  input  logic       ppu_hblank,
  input  logic       ppu_vblank,
  input  logic       lcd_on,
  input  logic       err_clr,
  output logic       lcd_ce,
  output logic [1:0] lcd_data,
  output logic       lcd_vs,
  output logic       ovf_err,
  output logic       short_err
);

  localparam logic [7:0]  PIX_FULL  = 8'(LINE_PIX);
  localparam logic [7:0]  MIN_LINES = 8'd144;
  localparam logic [16:0] OFF_LAST  = 17'(FRAME_CE - 1);

  typedef enum logic [2:0] {
    S_OFF,
    S_WAIT_VB,
    S_VBL,
    S_LINE,
    S_PAD,
    S_HBL
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  pix_cnt_q, pix_cnt_d;
  logic [7:0]  line_cnt_q, line_cnt_d;
  logic [16:0] off_cnt_q, off_cnt_d;
  logic        old_hblank_q, old_hblank_d;
  logic        old_vblank_q, old_vblank_d;
  logic        old_on_q, old_on_d;
  logic        lcd_ce_q, lcd_ce_d;
  logic [1:0]  lcd_data_q, lcd_data_d;
  logic        lcd_vs_q, lcd_vs_d;
  logic        ovf_err_q, ovf_err_d;
  logic        short_err_q, short_err_d;

  logic        hb_rise, hb_fall, vb_rise, vb_fall, on_rise, on_fall;
  logic        go_vbl, go_hbl, ovf_set, short_set;
  logic [7:0]  pix_next;

  assign hb_rise = ppu_hblank & ~old_hblank_q;
  assign hb_fall = ~ppu_hblank & old_hblank_q;
  assign vb_rise = ppu_vblank & ~old_vblank_q;
  assign vb_fall = ~ppu_vblank & old_vblank_q;
  assign on_rise = lcd_on & ~old_on_q;
  assign on_fall = ~lcd_on & old_on_q;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    state_d      = state_q;
    pix_cnt_d    = pix_cnt_q;
    line_cnt_d   = line_cnt_q;
    off_cnt_d    = off_cnt_q;
    old_hblank_d = old_hblank_q;
    old_vblank_d = old_vblank_q;
    old_on_d     = old_on_q;
    lcd_ce_d     = lcd_ce_q;
    lcd_data_d   = lcd_data_q;
    lcd_vs_d     = lcd_vs_q;
    ovf_err_d    = ovf_err_q;
    short_err_d  = short_err_q;
    go_vbl       = 1'b0;
    go_hbl       = 1'b0;
    ovf_set      = 1'b0;
    short_set    = 1'b0;
    pix_next     = pix_cnt_q;

    if (gb_ce) begin
      old_hblank_d = ppu_hblank;
      old_vblank_d = ppu_vblank;
      old_on_d     = lcd_on;
      lcd_ce_d     = 1'b0;

      // Losing the LCD abandons any partial line without padding it.
      if (on_fall && state_q != S_OFF) begin
        state_d  = S_OFF;
        lcd_vs_d = 1'b0;
      end else begin
        case (state_q)
          S_OFF: begin
            lcd_vs_d = 1'b0;
            if (on_rise) begin
              off_cnt_d  = '0;
              pix_cnt_d  = '0;
              line_cnt_d = '0;
              state_d    = S_WAIT_VB;
            end else if (off_cnt_q == OFF_LAST) begin
              off_cnt_d = '0;
              lcd_vs_d  = 1'b1;
            end else begin
              off_cnt_d = off_cnt_q + 17'd1;
            end
          end
          S_WAIT_VB: begin
            if (vb_rise) go_vbl = 1'b1;
          end
          S_VBL: begin
            if (vb_fall) begin
              state_d  = S_LINE;
              lcd_vs_d = 1'b0;
            end
          end
          S_LINE: begin
            if (vb_rise) begin
              go_vbl    = 1'b1;
              short_set = 1'b1;
            end else begin
              if (pix_valid) begin
                if (pix_cnt_q < PIX_FULL) begin
                  lcd_ce_d   = 1'b1;
                  lcd_data_d = pix_data;
                  pix_next   = pix_cnt_q + 8'd1;
                end else begin
                  ovf_set = 1'b1;
                end
              end
              pix_cnt_d = pix_next;
              if (hb_rise) begin
                if (pix_next == PIX_FULL) go_hbl = 1'b1;
                else                      state_d = S_PAD;
              end
            end
          end
          S_PAD: begin
            if (vb_rise) begin
              go_vbl    = 1'b1;
              short_set = 1'b1;
            end else begin
              if (pix_cnt_q < PIX_FULL) begin
                lcd_ce_d   = 1'b1;
                lcd_data_d = 2'd0;
                pix_next   = pix_cnt_q + 8'd1;
              end
              pix_cnt_d = pix_next;
              if (pix_next == PIX_FULL) go_hbl = 1'b1;
            end
          end
          S_HBL: begin
            if (vb_rise) begin
              go_vbl    = 1'b1;
              short_set = (line_cnt_q < MIN_LINES);
            end else if (hb_fall) begin
              state_d = S_LINE;
            end
          end
          default: state_d = S_OFF;
        endcase
      end

      if (go_vbl) begin
        state_d    = S_VBL;
        lcd_vs_d   = 1'b1;
        line_cnt_d = '0;
        pix_cnt_d  = '0;
      end
      if (go_hbl) begin
        state_d   = S_HBL;
        pix_cnt_d = '0;
        if (line_cnt_q != 8'hFF) line_cnt_d = line_cnt_q + 8'd1;
      end

      // A clear wins over a set landing on the same enable.
      if (err_clr) begin
        ovf_err_d   = 1'b0;
        short_err_d = 1'b0;
      end else begin
        ovf_err_d   = ovf_err_q | ovf_set;
        short_err_d = short_err_q | short_set;
      end
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_OFF;
      pix_cnt_q    <= '0;
      line_cnt_q   <= '0;
      off_cnt_q    <= '0;
      old_hblank_q <= 1'b0;
      old_vblank_q <= 1'b0;
      old_on_q     <= 1'b0;
      lcd_ce_q     <= 1'b0;
      lcd_data_q   <= 2'd0;
      lcd_vs_q     <= 1'b0;
      ovf_err_q    <= 1'b0;
      short_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      pix_cnt_q    <= pix_cnt_d;
      line_cnt_q   <= line_cnt_d;
      off_cnt_q    <= off_cnt_d;
      old_hblank_q <= old_hblank_d;
      old_vblank_q <= old_vblank_d;
      old_on_q     <= old_on_d;
      lcd_ce_q     <= lcd_ce_d;
      lcd_data_q   <= lcd_data_d;
      lcd_vs_q     <= lcd_vs_d;
      ovf_err_q    <= ovf_err_d;
      short_err_q  <= short_err_d;
    end
  end

  assign lcd_ce    = lcd_ce_q;
  assign lcd_data  = lcd_data_q;
  assign lcd_vs    = lcd_vs_q;
  assign ovf_err   = ovf_err_q;
  assign short_err = short_err_q;

endmodule

// File: tb/tb_sgb_lcd_tap.sv
// Directed bench for sgb_lcd_tap: LCD-off vsync, full frame, padding, overflow,
// error clearing, LCD-off mid-line, enable gating and mid-frame reset.
module tb_sgb_lcd_tap;

  localparam int F = 300;  // shortened synthetic frame keeps the run small

  logic       clk = 1'b0;
  logic       reset, gb_ce, pix_valid, ppu_hblank, ppu_vblank, lcd_on, err_clr;
  logic [1:0] pix_data;
  logic       lcd_ce, lcd_vs, ovf_err, short_err;
  logic [1:0] lcd_data;

  int   errors = 0;
  int   checks = 0;
  int   ce_cnt, zero_cnt, vs_rise, vs_hi, vs_first, vs_last, en_idx, bad;
  logic vs_prev;
  logic hold_ce;
  logic [1:0] hold_data;

  always #5 clk = ~clk;

  sgb_lcd_tap #(.LINE_PIX(160), .FRAME_CE(F)) dut (
    .clk        (clk),
    .reset      (reset),
    .gb_ce      (gb_ce),
    .pix_valid  (pix_valid),
    .pix_data   (pix_data),
    .ppu_hblank (ppu_hblank),
    .ppu_vblank (ppu_vblank),
    .lcd_on     (lcd_on),
    .err_clr    (err_clr),
    .lcd_ce     (lcd_ce),
    .lcd_data   (lcd_data),
    .lcd_vs     (lcd_vs),
    .ovf_err    (ovf_err),
    .short_err  (short_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One enable cycle; outputs are sampled 1 time unit after the edge.
  task automatic en();
    gb_ce = 1'b1;
    @(posedge clk);
    #1;
    gb_ce = 1'b0;
    if (lcd_ce === 1'b1) begin
      ce_cnt++;
      if (lcd_data === 2'd0) zero_cnt++;
    end
    if (lcd_vs === 1'b1) begin
      vs_hi++;
      if (vs_prev !== 1'b1) begin
        vs_rise++;
        if (vs_rise == 1) vs_first = en_idx;
        vs_last = en_idx;
      end
    end
    vs_prev = lcd_vs;
    en_idx++;
  endtask

  task automatic idle();
    gb_ce = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic clr_stats();
    ce_cnt = 0; zero_cnt = 0; vs_rise = 0; vs_hi = 0;
    en_idx = 0; vs_first = -1; vs_last = -1;
  endtask

  initial begin
    reset = 1'b1; gb_ce = 1'b0; pix_valid = 1'b0; pix_data = 2'd0;
    ppu_hblank = 1'b0; ppu_vblank = 1'b0; lcd_on = 1'b0; err_clr = 1'b0;
    vs_prev = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset_lcd_ce", lcd_ce, 0);
    check("reset_lcd_data", lcd_data, 0);
    check("reset_lcd_vs", lcd_vs, 0);
    check("reset_ovf_err", ovf_err, 0);
    check("reset_short_err", short_err, 0);

    // LCD off: synthetic vsync every F enables, one enable wide.
    clr_stats();
    repeat (3 * F) en();
    check("off_vs_count", vs_rise, 3);
    check("off_vs_first", vs_first, F - 1);
    check("off_vs_spacing", vs_last - vs_first, 2 * F);
    check("off_vs_width", vs_hi, 3);
    check("off_no_ce", ce_cnt, 0);

    // LCD on: nothing emitted until a VBlank is seen.
    lcd_on = 1'b1; en();
    clr_stats();
    pix_valid = 1'b1; pix_data = 2'd3;
    repeat (20) en();
    ppu_hblank = 1'b1; en();
    ppu_hblank = 1'b0; en();
    check("wait_vb_no_ce", ce_cnt, 0);
    pix_valid = 1'b0; ppu_vblank = 1'b1; en();
    check("vbl_entry_vs", lcd_vs, 1);
    repeat (5) en();
    ppu_vblank = 1'b0; en();
    check("vbl_exit_vs", lcd_vs, 0);

    // Normal frame: 144 full lines.
    clr_stats(); bad = 0;
    for (int ln = 0; ln < 144; ln++) begin
      pix_valid = 1'b1;
      for (int p = 0; p < 160; p++) begin
        pix_data = 2'((p + ln) % 4);
        en();
        if (lcd_ce !== 1'b1 || lcd_data !== pix_data) bad++;
      end
      pix_valid = 1'b0; ppu_hblank = 1'b1;
      repeat (12) en();
      if (ln != 143) begin
        ppu_hblank = 1'b0; en();
      end
    end
    check("frame_ce_count", ce_cnt, 23040);
    check("frame_data", bad, 0);
    check("frame_no_extra_vs", vs_rise, 0);
    ppu_vblank = 1'b1; en();
    check("frame_end_vs", lcd_vs, 1);
    check("frame_ovf_err", ovf_err, 0);
    check("frame_short_err", short_err, 0);
    repeat (3) en();

    // Short line: 150 pixels, then 10 zero pads.
    ppu_hblank = 1'b0; ppu_vblank = 1'b0; en();
    clr_stats();
    pix_valid = 1'b1; pix_data = 2'd3;
    repeat (150) en();
    pix_valid = 1'b0; ppu_hblank = 1'b1; en();
    check("short_hb_no_ce", lcd_ce, 0);
    repeat (10) en();
    check("pad_count", zero_cnt, 10);
    check("pad_data", lcd_data, 0);
    check("pad_line_total", ce_cnt, 160);
    en();
    check("pad_stop", lcd_ce, 0);
    repeat (3) en();

    // Overflow: 165 pixels in one line.
    ppu_hblank = 1'b0; en();
    clr_stats();
    pix_valid = 1'b1; pix_data = 2'd1;
    repeat (160) en();
    check("ovf_at_160", ovf_err, 0);
    en();
    check("ovf_set", ovf_err, 1);
    check("ovf_drop_ce", lcd_ce, 0);
    repeat (4) en();
    check("ovf_ce_count", ce_cnt, 160);
    pix_valid = 1'b0; err_clr = 1'b1; en();
    err_clr = 1'b0;
    check("ovf_clr", ovf_err, 0);
    ppu_hblank = 1'b1; en();
    ppu_hblank = 1'b0; en();
    pix_valid = 1'b1;
    repeat (160) en();
    err_clr = 1'b1; en();
    check("ovf_clr_priority", ovf_err, 0);
    err_clr = 1'b0; en();
    check("ovf_set_again", ovf_err, 1);

    // VBlank after only three lines.
    pix_valid = 1'b0; ppu_hblank = 1'b1; en();
    ppu_vblank = 1'b1; en();
    check("short_err_set", short_err, 1);
    check("short_vs", lcd_vs, 1);
    err_clr = 1'b1; en();
    err_clr = 1'b0;
    check("short_err_clr", short_err, 0);
    check("ovf_err_clr2", ovf_err, 0);

    // LCD off mid-line, then back on.
    ppu_hblank = 1'b0; ppu_vblank = 1'b0; en();
    clr_stats();
    pix_valid = 1'b1; pix_data = 2'd2;
    repeat (80) en();
    lcd_on = 1'b0; en();
    check("off_midline_ce", lcd_ce, 0);
    repeat (20) en();
    lcd_on = 1'b1; en();
    repeat (10) en();
    ppu_hblank = 1'b1; en();
    ppu_hblank = 1'b0;
    repeat (5) en();
    check("off_total_ce", ce_cnt, 80);
    ppu_vblank = 1'b1; en();
    check("reon_vs", lcd_vs, 1);
    repeat (4) en();
    pix_data = 2'd1; ppu_vblank = 1'b0; en();
    check("vbl_fall_no_ce", ce_cnt, 80);
    en();
    check("first_pix_ce", lcd_ce, 1);
    check("first_pix_data", lcd_data, 1);

    // Enable gating: gb_ce every 4th clock, pix_valid held high.
    clr_stats(); bad = 0;
    for (int k = 0; k < 8; k++) begin
      hold_ce = lcd_ce; hold_data = lcd_data;
      for (int i = 0; i < 3; i++) begin
        pix_data = 2'd3;
        idle();
        if (lcd_ce !== hold_ce || lcd_data !== hold_data || lcd_vs !== 1'b0) bad++;
      end
      pix_data = 2'(k % 3);
      en();
      if (lcd_ce !== 1'b1 || lcd_data !== pix_data) bad++;
    end
    check("gate_hold", bad, 0);
    pix_valid = 1'b0; ppu_hblank = 1'b1; en();
    repeat (151) en();
    check("gate_line_total", ce_cnt, 159);
    en();
    check("gate_pad_done", lcd_ce, 0);

    // Reset mid-line returns to OFF and waits for a fresh VBlank.
    ppu_hblank = 1'b0; en();
    pix_valid = 1'b1; pix_data = 2'd3;
    repeat (5) en();
    check("pre_reset_ce", lcd_ce, 1);
    reset = 1'b1; idle();
    reset = 1'b0;
    check("midreset_lcd_ce", lcd_ce, 0);
    check("midreset_lcd_data", lcd_data, 0);
    clr_stats();
    repeat (10) en();
    check("post_reset_no_ce", ce_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sgb_lcd_tap.md
# sgb_lcd_tap

Sits between the Game Boy PPU and the ICD2 tile-capture stage, on the same clock and clock-enable domain. Turns the PPU pixel stream into the strict 160-pixel-per-line LCD stream that the ICD2 packs into 2bpp character data. Guarantees whole lines by zero-padding short lines and dropping excess pixels. Keeps frame timing alive while the LCD is off by generating a vsync every 70224 enables.

## Interface
- `LINE_PIX`, 160, pixels per emitted line.
- `FRAME_CE`, 70224, gb_ce count per synthetic frame while the LCD is off.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `gb_ce` in 1: GB clock enable, the same `gb_clk_en` that the ICD2 uses.
- `pix_valid` in 1: PPU pixel strobe. Meaningful only when `gb_ce` is high.
- `pix_data` in 2: PPU shade, 0–3.
- `ppu_hblank` in 1: level, high during HBlank.
- `ppu_vblank` in 1: level, high during VBlank.
- `lcd_on` in 1: LCDC bit 7.
- `lcd_ce` out 1: one emitted pixel. Consumed by ICD2 on the next `gb_ce`.
- `lcd_data` out 2: shade of the emitted pixel.
- `lcd_vs` out 1: frame start level. ICD2 detects its rising edge.
- `ovf_err` out 1: sticky flag, more than `LINE_PIX` pixels seen in one line.
- `short_err` out 1: sticky flag, VBlank reached with fewer than 144 lines.
- `err_clr` in 1: clears both sticky flags. Has priority over a same-cycle set.

## Operation
- All state advances only on cycles where `gb_ce` = 1. Between enables, every output holds.
- Counters:
  - `pix_cnt`, 8 bits, range 0–160.
  - `line_cnt`, 8 bits, saturates at 255.
  - `off_cnt`, 17 bits, range 0 to `FRAME_CE`−1.
- Edge detection uses `old_hblank`, `old_vblank` and `old_on`, registered on `gb_ce`.
- States:
  - **OFF**: entered from reset, or when `lcd_on` falls. `lcd_ce`=0. `off_cnt` increments on each `gb_ce`. When it reaches `FRAME_CE`−1: wrap to 0 and set `lcd_vs`=1 for exactly one `gb_ce` period. A rising `lcd_on` clears `off_cnt`, `pix_cnt` and `line_cnt`, then moves to **WAIT_VB**.
  - **WAIT_VB**: `lcd_ce`=0. The first rising edge of `ppu_vblank` moves to **VBL**. This avoids emitting a torn first frame.
  - **VBL**: on entry, `lcd_vs`=1. `line_cnt` and `pix_cnt` are cleared. A falling `ppu_vblank` moves to **LINE** and drops `lcd_vs` to 0.
  - **LINE**: when `pix_valid` is high:
    - If `pix_cnt` < 160: `lcd_ce`=1, `lcd_data`=`pix_data`, `pix_cnt`+1.
    - Otherwise: drop the pixel and set `ovf_err`.
    - A rising `ppu_hblank` with `pix_cnt` = 160 moves to **HBL**. With `pix_cnt` < 160 it moves to **PAD**.
  - **PAD**: emits `lcd_ce`=1, `lcd_data`=0 on each `gb_ce` until `pix_cnt` = 160, then moves to **HBL**. `pix_valid` is ignored here.
  - **HBL**: `lcd_ce`=0. `line_cnt`+1 and `pix_cnt`=0, both on entry. A falling `ppu_hblank` moves to **LINE**. A rising `ppu_vblank` moves to **VBL**, and sets `short_err` if `line_cnt` < 144.
- Global transitions:
  - A rising `ppu_vblank` in **LINE** or **PAD** aborts padding, sets `short_err` and moves to **VBL**.
  - A falling `lcd_on` in any state except **OFF**: moves to **OFF** and `lcd_ce`=0 on the same enable. A partial line is not padded.
- Outputs while not emitting:
  - `lcd_ce`=0 on every enable that does not emit a pixel.
  - `lcd_data` holds its last value.

## Timing
- Reset values:
  - State **OFF**.
  - `lcd_ce`=0, `lcd_data`=0, `lcd_vs`=0.
  - `ovf_err`=0, `short_err`=0.
  - All counters 0.
- Latency: a pixel accepted on enable *n* appears on `lcd_ce`/`lcd_data` registered at enable *n*. The ICD2 samples it at enable *n*+1.
- Back-to-back pixels on consecutive enables produce a continuous `lcd_ce` level. Each enable counts as one pixel.
- `lcd_vs` rises registered at the VBL-entry enable and stays high at least until the next enable.
- Reset mid-frame returns to **OFF**. The next frame emitted is the first full frame after `lcd_on` and a VBlank are seen.

## Test plan
- **Normal frame.** Stimulus: 144 lines of 160 `pix_valid` each, HBlank after each line, then VBlank. Required: exactly 23040 `lcd_ce` enables, one `lcd_vs` rise, both error flags 0.
- **Short line.** Stimulus: 150 pixels of shade 3, then HBlank. Required: 10 further `lcd_ce` enables with `lcd_data`=0, then `pix_cnt`=0. Line total is 160.
- **Overflow.** Stimulus: 165 pixels before HBlank. Required: 160 `lcd_ce` enables, `ovf_err`=1. A same-cycle `err_clr` leaves it at 0.
- **LCD off.** Stimulus: `lcd_on`=0 for 3×70224 enables. Required: three `lcd_vs` pulses 70224 enables apart, no `lcd_ce`.
- **LCD off mid-line, then back on.** Stimulus: `lcd_on` falls at pixel 80; later `lcd_on` rises. Required: `lcd_ce`=0 from the falling edge. No pixels are emitted until the next VBlank's falling edge.
- **Enable gating.** Stimulus: `gb_ce`=1 every 4th clock, with `pix_valid` held high while `gb_ce`=0. Required: state and outputs change only on enable cycles.
